// File: rtl/fetch_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU: owns PC and IR, runs the
// FETCH/DECODE/EXEC/MEM/WB walk and drives the memory handshake and write enables.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ready,
  input  logic [15:0] i_data_addr,
  input  logic [15:0] i_jump_target,
  input  logic        i_cond_true,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_instruction,
  output logic [15:0] o_pc,
  output logic        o_reg_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_psr_we,
  output logic [15:0] o_load_data
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU   = 3'd0,
    C_CMP   = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_BCOND = 3'd4,
    C_JCOND = 3'd5,
    C_JAL   = 3'd6
  } cls_t;

  // Undefined encodings fall through to ALU so every IR value has a defined walk.
  function automatic cls_t decode_class(input logic [15:0] ir);
    cls_t c;
    c = C_ALU;
    case (ir[15:12])
      4'b0100: begin
        case (ir[7:4])
          4'b0000: c = C_LOAD;
          4'b0100: c = C_STORE;
          4'b1100: c = C_JCOND;
          4'b1000: c = C_JAL;
          default: c = C_ALU;
        endcase
      end
      4'b1100: c = C_BCOND;
      4'b1011: c = C_CMP;
      4'b0000: begin
        if (ir[7:4] == 4'b1011) begin
          c = C_CMP;
        end else begin
          c = C_ALU;
        end
      end
      default: c = C_ALU;
    endcase
    return c;
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] w_pc_next;
  logic [15:0] r_ir;
  logic [15:0] w_ir_next;
  logic [15:0] r_ir_pc;
  logic [15:0] w_ir_pc_next;
  logic [15:0] r_load_data;
  logic [15:0] w_load_data_next;
  logic        r_req;
  logic        w_req_next;
  cls_t        w_cls;
  logic [15:0] w_branch_off;

  assign w_cls         = decode_class(r_ir);
  assign w_branch_off  = {{8{r_ir[7]}}, r_ir[7:0]};
  assign o_pc          = r_pc;
  assign o_instruction = r_ir;
  assign o_load_data   = r_load_data;

  // State and datapath-control registers; reset drops every request at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_RST;
      r_pc        <= RESET_PC;
      r_ir        <= 16'h0000;
      r_ir_pc     <= 16'h0000;
      r_load_data <= 16'h0000;
      r_req       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_ir        <= w_ir_next;
      r_ir_pc     <= w_ir_pc_next;
      r_load_data <= w_load_data_next;
      r_req       <= w_req_next;
    end
  end

  // Next-state, register updates and handshake/enable outputs.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_ir_next        = r_ir;
    w_ir_pc_next     = r_ir_pc;
    w_load_data_next = r_load_data;
    w_req_next       = r_req;
    o_mem_addr       = 16'h0000;
    o_mem_rd         = 1'b0;
    o_mem_wr         = 1'b0;
    o_reg_we         = 1'b0;
    o_wb_sel         = 2'd0;
    o_psr_we         = 1'b0;

    case (r_state)
      S_RST: begin
        w_state_next = S_FETCH;
      end

      S_FETCH: begin
        o_mem_addr = r_pc;
        // stall only gates a request that has not been issued yet
        if (i_stall && !r_req) begin
          o_mem_rd = 1'b0;
        end else begin
          o_mem_rd = 1'b1;
          if (i_mem_ready) begin
            w_ir_next    = i_mem_rdata;
            w_ir_pc_next = r_pc;
            w_pc_next    = r_pc + 16'd1;
            w_req_next   = 1'b0;
            w_state_next = S_DECODE;
          end else begin
            w_req_next = 1'b1;
          end
        end
      end

      S_DECODE: begin
        w_state_next = S_EXEC;
      end

      S_EXEC: begin
        w_state_next = S_FETCH;
        case (w_cls)
          C_ALU: begin
            o_reg_we = 1'b1;
            o_psr_we = 1'b1;
          end
          C_CMP: begin
            o_psr_we = 1'b1;
          end
          C_LOAD, C_STORE: begin
            w_state_next = S_MEM;
          end
          C_BCOND: begin
            if (i_cond_true) begin
              w_pc_next = r_ir_pc + w_branch_off;
            end else begin
              w_pc_next = r_pc;
            end
          end
          C_JCOND: begin
            if (i_cond_true) begin
              w_pc_next = i_jump_target;
            end else begin
              w_pc_next = r_pc;
            end
          end
          C_JAL: begin
            o_reg_we  = 1'b1;
            o_wb_sel  = 2'd2;
            w_pc_next = i_jump_target;
          end
          default: begin
            w_state_next = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        o_mem_addr = i_data_addr;
        if (w_cls == C_LOAD) begin
          o_mem_rd = 1'b1;
        end else begin
          o_mem_wr = 1'b1;
        end
        if (i_mem_ready) begin
          if (w_cls == C_LOAD) begin
            w_load_data_next = i_mem_rdata;
            w_state_next     = S_WB;
          end else begin
            w_state_next = S_FETCH;
          end
        end else begin
          w_state_next = S_MEM;
        end
      end

      S_WB: begin
        o_reg_we     = 1'b1;
        o_wb_sel     = 2'd1;
        w_state_next = S_FETCH;
      end

      default: begin
        w_state_next = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed instruction table, hand-written
// handshake/stall/reset sequences, then random programs checked by an instruction-level model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] data_addr;
  logic [15:0] jump_target;
  logic        cond_true;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        psr_we;
  logic [15:0] load_data;

  logic [15:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  fetch_sequencer #(.RESET_PC(16'h0000)) dut (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_mem_rdata(mem_rdata),
    .i_mem_ready(mem_ready), .i_data_addr(data_addr), .i_jump_target(jump_target),
    .i_cond_true(cond_true), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
    .o_instruction(instruction), .o_pc(pc), .o_reg_we(reg_we), .o_wb_sel(wb_sel),
    .o_psr_we(psr_we), .o_load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string ctx     = "";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", ctx, name, act, exp);
    end
  endtask

  // Instruction classes: 0 ALU 1 CMP 2 LOAD 3 STORE 4 BCOND 5 JCOND 6 JAL
  function automatic int ref_class(input logic [15:0] ir);
    logic [3:0] op, ext;
    op  = ir[15:12];
    ext = ir[7:4];
    if (op == 4'h4 && ext == 4'h0) return 2;
    if (op == 4'h4 && ext == 4'h4) return 3;
    if (op == 4'h4 && ext == 4'hC) return 5;
    if (op == 4'h4 && ext == 4'h8) return 6;
    if (op == 4'hC) return 4;
    if (op == 4'hB || (op == 4'h0 && ext == 4'hB)) return 1;
    return 0;
  endfunction

  int       base_tab [7] = '{3, 3, 5, 4, 3, 3, 3};
  int       we_tab   [7] = '{1, 0, 1, 0, 0, 0, 1};
  int       wb_tab   [7] = '{0, 0, 1, 0, 0, 0, 2};
  int       psr_tab  [7] = '{1, 1, 0, 0, 0, 0, 0};
  int       dacc_tab [7] = '{0, 0, 1, 2, 0, 0, 0};

  int          obs_we, obs_psr, obs_drd, obs_dwr, obs_bad, obs_both;
  logic [1:0]  obs_wb;
  logic [15:0] obs_link;

  // Runs one instruction from a FETCH-cycle negedge to the next FETCH-cycle negedge.
  task automatic run_instr(input logic [15:0] pc0, input logic [15:0] ir, input logic [15:0] da,
                           input logic [15:0] jt, input logic cond, input int base, input bit rnd);
    int cyc, waits;
    mem[pc0] = ir;
    data_addr = da; jump_target = jt; cond_true = cond; stall = 1'b0;
    obs_we = 0; obs_psr = 0; obs_drd = 0; obs_dwr = 0; obs_bad = 0; obs_both = 0;
    obs_wb = 2'd0; obs_link = 16'h0000;
    cyc = 0; waits = 0;
    while (cyc < base + waits && cyc < 64) begin
      mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (mem_rd && mem_wr) obs_both++;
      if (mem_rd || mem_wr) begin
        if (!mem_ready) waits++;
        if (mem_addr == da) begin
          if (mem_rd) obs_drd++;
          if (mem_wr) obs_dwr++;
        end else if (mem_addr != pc0 || mem_wr) begin
          obs_bad++;
        end
      end
      if (reg_we) begin obs_we++; obs_wb = wb_sel; obs_link = pc; end
      if (psr_we) obs_psr++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 64) check("cycle_budget", cyc, base + waits);
    mem_ready = 1'b1;
    #1;
  endtask

  task automatic expect_instr(input logic [15:0] pc0, input logic [15:0] ir, input logic [15:0] exp_pc,
                              input int we, input logic [1:0] wb, input int psr, input int dacc,
                              input logic [15:0] ld);
    logic [15:0] link_e;
    link_e = pc0 + 16'd1;
    check("next_fetch_rd", mem_rd, 1'b1);
    check("next_fetch_addr", mem_addr, exp_pc);
    check("pc", pc, exp_pc);
    check("ir", instruction, ir);
    check("reg_we_pulses", obs_we, we);
    if (we > 0) check("wb_sel", obs_wb, wb);
    if (we > 0 && wb == 2'd2) check("link_pc", obs_link, link_e);
    check("psr_we_pulses", obs_psr, psr);
    check("data_rd", obs_drd > 0, dacc == 1);
    check("data_wr", obs_dwr > 0, dacc == 2);
    check("bus_protocol", obs_bad + obs_both, 0);
    if (dacc == 1) check("load_data", load_data, ld);
  endtask

  typedef struct {
    logic [15:0] ir; logic cond; logic [15:0] jt; logic [15:0] da;
    int base; int we; logic [1:0] wb; int psr; int dacc; logic [15:0] ld; logic [15:0] exp_pc;
  } vec_t;
  vec_t vecs [15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pc_m, ir, da, jt, exp_pc, off, ld;
    logic        cond;
    int          cls, sel;

    vecs[0]  = '{16'h0051, 1'b0, 16'h0000, 16'hA000, 3, 1, 2'd0, 1, 0, 16'h0000, 16'h0001};
    vecs[1]  = '{16'h00B0, 1'b0, 16'h0000, 16'hA000, 3, 0, 2'd0, 1, 0, 16'h0000, 16'h0002};
    vecs[2]  = '{16'hB123, 1'b0, 16'h0000, 16'hA000, 3, 0, 2'd0, 1, 0, 16'h0000, 16'h0003};
    vecs[3]  = '{16'h4040, 1'b0, 16'h0000, 16'h0100, 4, 0, 2'd0, 0, 2, 16'h0000, 16'h0004};
    vecs[4]  = '{16'h4000, 1'b0, 16'h0000, 16'h0200, 5, 1, 2'd1, 0, 1, 16'hCAFE, 16'h0005};
    vecs[5]  = '{16'h4080, 1'b0, 16'h1234, 16'hA000, 3, 1, 2'd2, 0, 0, 16'h0000, 16'h1234};
    vecs[6]  = '{16'h40C0, 1'b0, 16'h3000, 16'hA000, 3, 0, 2'd0, 0, 0, 16'h0000, 16'h1235};
    vecs[7]  = '{16'h40C0, 1'b1, 16'h0010, 16'hA000, 3, 0, 2'd0, 0, 0, 16'h0000, 16'h0010};
    vecs[8]  = '{16'hC0FE, 1'b1, 16'h0000, 16'hA000, 3, 0, 2'd0, 0, 0, 16'h0000, 16'h000E};
    vecs[9]  = '{16'hC0FE, 1'b0, 16'h0000, 16'hA000, 3, 0, 2'd0, 0, 0, 16'h0000, 16'h000F};
    vecs[10] = '{16'h4010, 1'b0, 16'h0000, 16'hA000, 3, 1, 2'd0, 1, 0, 16'h0000, 16'h0010};
    vecs[11] = '{16'hC080, 1'b1, 16'h0000, 16'hA000, 3, 0, 2'd0, 0, 0, 16'h0000, 16'hFF90};
    vecs[12] = '{16'h40C0, 1'b1, 16'hFFFF, 16'hA000, 3, 0, 2'd0, 0, 0, 16'h0000, 16'hFFFF};
    vecs[13] = '{16'hF0F0, 1'b0, 16'h0000, 16'hA000, 3, 1, 2'd0, 1, 0, 16'h0000, 16'h0000};
    vecs[14] = '{16'hC17F, 1'b1, 16'h0000, 16'hA000, 3, 0, 2'd0, 0, 0, 16'h0000, 16'h007F};

    rst = 1'b1; stall = 1'b0; mem_ready = 1'b0; data_addr = 16'h0000;
    jump_target = 16'h0000; cond_true = 1'b0;
    mem[16'h0200] = 16'hCAFE;

    // Reset state, then first fetch one cycle after release
    ctx = "reset";
    @(negedge clk); @(negedge clk);
    check("rst_bus", {mem_addr, mem_rd, mem_wr, reg_we, wb_sel, psr_we}, 32'h0);
    check("rst_pc_ir", {pc, instruction}, 32'h0);
    rst = 1'b0; mem_ready = 1'b1;
    #1 check("rst_state_rd", mem_rd, 1'b0);
    @(negedge clk);
    #1 check("first_fetch", {15'h0, mem_rd, mem_addr}, {15'h0, 1'b1, 16'h0000});

    // Directed instruction table, memory always ready
    pc_m = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      ctx = $sformatf("vec%0d", i);
      run_instr(pc_m, vecs[i].ir, vecs[i].da, vecs[i].jt, vecs[i].cond, vecs[i].base, 1'b0);
      expect_instr(pc_m, vecs[i].ir, vecs[i].exp_pc, vecs[i].we, vecs[i].wb, vecs[i].psr,
                   vecs[i].dacc, vecs[i].ld);
      pc_m = vecs[i].exp_pc;
    end

    // LOAD with memory held off for two MEM cycles
    ctx = "load_wait";
    mem[16'h007F] = 16'h4000; mem[16'h0020] = 16'hBEEF; data_addr = 16'h0020; mem_ready = 1'b1;
    check("fetch_addr", mem_addr, 16'h007F);
    @(negedge clk); @(negedge clk); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      #1 check($sformatf("mem_rd_held%0d", k), {15'h0, mem_rd, mem_addr}, {15'h0, 1'b1, 16'h0020});
      @(negedge clk);
    end
    #1 check("wb_enables", {reg_we, wb_sel}, {1'b1, 2'd1});
    @(negedge clk);
    #1 check("next_fetch", {mem_rd, mem_addr}, {1'b1, 16'h0080});
    check("load_data", load_data, 16'hBEEF);

    // stall holds off the fetch even with memory ready, but not an issued request
    ctx = "stall";
    mem[16'h0080] = 16'h0051; stall = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("stalled_rd%0d", k), {mem_rd, instruction}, {1'b0, 16'h4000});
      @(negedge clk);
    end
    stall = 1'b0; mem_ready = 1'b0;
    #1 check("issue", {mem_rd, mem_addr}, {1'b1, 16'h0080});
    @(negedge clk); stall = 1'b1;
    #1 check("held_under_stall", mem_rd, 1'b1);
    @(negedge clk); mem_ready = 1'b1;
    #1 check("held_to_ready", mem_rd, 1'b1);
    @(negedge clk); stall = 1'b0;
    #1 check("ir_after_stall", {instruction, pc}, {16'h0051, 16'h0081});
    @(negedge clk);
    #1 check("exec_we", reg_we, 1'b1);
    @(negedge clk);
    #1 check("fetch_after", {mem_rd, mem_addr}, {1'b1, 16'h0081});

    // Reset arriving while a STORE waits in MEM
    ctx = "reset_store";
    mem[16'h0081] = 16'h4040; data_addr = 16'h0300; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_ready = 1'b0;
    #1 check("store_wr", {mem_wr, mem_addr}, {1'b1, 16'h0300});
    #1 rst = 1'b1;
    #1 check("wr_drop", {mem_wr, mem_rd}, 2'b00);
    @(negedge clk);
    check("rst_pc_ir", {pc, instruction}, 32'h0);
    rst = 1'b0; mem_ready = 1'b1;
    #1 check("rst_state_rd", mem_rd, 1'b0);
    @(negedge clk);
    #1 check("refetch", {mem_rd, mem_addr}, {1'b1, 16'h0000});

    // Random programs against the instruction-level model
    pc_m = 16'h0000;
    for (int n = 0; n < 80; n++) begin
      ctx = $sformatf("rand%0d", n);
      sel = $urandom_range(0, 3);
      case (sel)
        0: ir = 16'($urandom);
        1: ir = {4'h4, 4'($urandom), 4'($urandom_range(0, 3) * 4), 4'($urandom)};
        2: ir = {4'hC, 12'($urandom)};
        default: ir = {4'h0, 4'($urandom), 4'hB, 4'($urandom)};
      endcase
      cls = ref_class(ir);
      do da = 16'($urandom); while (da == pc_m);
      jt = 16'($urandom);
      cond = 1'($urandom);
      ld = 16'($urandom);
      mem[da] = ld;
      off = {{8{ir[7]}}, ir[7:0]};
      case (cls)
        4: exp_pc = cond ? 16'(int'(pc_m) + int'($signed(off))) : pc_m + 16'd1;
        5: exp_pc = cond ? jt : pc_m + 16'd1;
        6: exp_pc = jt;
        default: exp_pc = pc_m + 16'd1;
      endcase
      run_instr(pc_m, ir, da, jt, cond, base_tab[cls], 1'b1);
      expect_instr(pc_m, ir, exp_pc, we_tab[cls], 2'(wb_tab[cls]), psr_tab[cls], dacc_tab[cls], ld);
      pc_m = exp_pc;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
